// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the fetch PC, the branch-epoch ID (brid) and start/halt control for
//   the fetch stage. Each cycle it presents the instruction-memory address and
//   the fetch stage's pc_i/brid_i/branch_i inputs. It accepts branch redirects
//   from execute, discarding any whose epoch does not match the current one,
//   and halt requests from decode.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   start_i      start fetching at start_pc_i (honoured in IDLE/HALT only)
//   start_pc_i   start address
//   stall_i      hold request from the fetch stage
//   br_taken_i   redirect request from execute
//   br_target_i  redirect target
//   br_id_i      epoch of the redirecting instruction
//   halt_i       halt request from decode
//   pc_o         fetch address / fetch-stage pc_i
//   brid_o       current epoch / fetch-stage brid_i
//   branch_o     current fetch is invalid (fetch-stage branch_i)
//   flush_o      one-cycle pulse: squash epochs older than brid_o
//   halted_o     high in HALT
//   state_o      IDLE=0, RUN=1, HALT=2
//
// Redirect acceptance: a redirect is a single-cycle request with no ready
// back-pressure. It is accepted in the cycle br_taken_i is high, br_id_i
// equals brid_o and the FSM is in RUN or HALT; otherwise it is dropped and
// has no effect. Results of acceptance appear on the outputs one cycle later.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                 ADDR         = 16,
    parameter int                 W_BRID       = 4,
    parameter logic [ADDR-1:0]    RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR-1:0]   start_pc_i,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [ADDR-1:0]   br_target_i,
    input  logic [W_BRID-1:0] br_id_i,
    input  logic              halt_i,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_BRID-1:0] brid_o,
    output logic              branch_o,
    output logic              flush_o,
    output logic              halted_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR-1:0]   pc_q;
    logic [W_BRID-1:0] brid_q;
    logic              flush_q;
    logic              halted_q;

    logic              redir;
    logic [ADDR-1:0]   pc_inc;
    logic [W_BRID-1:0] brid_inc;

    // Only a redirect from the current epoch is meaningful; older ones come
    // from instructions already on a squashed path.
    assign redir    = br_taken_i && (br_id_i == brid_q);
    assign pc_inc   = pc_q + ADDR'(1);
    assign brid_inc = brid_q + W_BRID'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VECTOR;
            brid_q   <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        pc_q    <= start_pc_i;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (redir) begin
                        pc_q    <= br_target_i;
                        brid_q  <= brid_inc;
                        flush_q <= 1'b1;
                    end else if (halt_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (!stall_i) begin
                        pc_q <= pc_inc;
                    end
                end
                ST_HALT: begin
                    // A redirect here means the halt came from a wrong path.
                    if (redir) begin
                        pc_q     <= br_target_i;
                        brid_q   <= brid_inc;
                        flush_q  <= 1'b1;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (start_i) begin
                        pc_q     <= start_pc_i;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    // Encoding 3 is unreachable; recover to IDLE.
                    state_q  <= ST_IDLE;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // The fetch being latched this cycle is wrong-path when a redirect is
    // accepted, so it is killed combinationally.
    assign branch_o = (state_q != ST_RUN) || redir;
    assign pc_o     = pc_q;
    assign brid_o   = brid_q;
    assign flush_o  = flush_q;
    assign halted_o = halted_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int ADDR   = 16;
  localparam int W_BRID = 4;
  localparam int OBS_W  = 2 + 1 + 1 + 1 + W_BRID + ADDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              start_i = 1'b0;
  logic [ADDR-1:0]   start_pc_i = '0;
  logic              stall_i = 1'b0;
  logic              br_taken_i = 1'b0;
  logic [ADDR-1:0]   br_target_i = '0;
  logic [W_BRID-1:0] br_id_i = '0;
  logic              halt_i = 1'b0;
  logic [ADDR-1:0]   pc_o;
  logic [W_BRID-1:0] brid_o;
  logic              branch_o;
  logic              flush_o;
  logic              halted_o;
  logic [1:0]        state_o;

  fetch_sequencer #(.ADDR(ADDR), .W_BRID(W_BRID), .RESET_VECTOR(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .start_pc_i  (start_pc_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .br_id_i     (br_id_i),
    .halt_i      (halt_i),
    .pc_o        (pc_o),
    .brid_o      (brid_o),
    .branch_o    (branch_o),
    .flush_o     (flush_o),
    .halted_o    (halted_o),
    .state_o     (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [OBS_W-1:0] pack(input int st, input int h, input int f,
                                            input int b, input int brid, input int pc);
    logic [1:0]        s2;
    logic [W_BRID-1:0] bi;
    logic [ADDR-1:0]   p;
    s2 = st[1:0];
    bi = brid[W_BRID-1:0];
    p  = pc[ADDR-1:0];
    return {s2, h[0], f[0], b[0], bi, p};
  endfunction

  function automatic logic [OBS_W-1:0] actual();
    return {state_o, halted_o, flush_o, branch_o, brid_o, pc_o};
  endfunction

  // Monitor: every cycle the DUT presents one observation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OBS_W-1:0] e;
      logic [OBS_W-1:0] a;
      e = exp_q.pop_front();
      a = actual();
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL obs#%0d got st=%0d h=%0b f=%0b br=%0b brid=%0d pc=%h want st=%0d h=%0b f=%0b br=%0b brid=%0d pc=%h",
                    n_checks, a[OBS_W-1 -: 2], a[OBS_W-3], a[OBS_W-4], a[OBS_W-5],
                    a[ADDR +: W_BRID], a[ADDR-1:0], e[OBS_W-1 -: 2], e[OBS_W-3],
                    e[OBS_W-4], e[OBS_W-5], e[ADDR +: W_BRID], e[ADDR-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [ADDR-1:0] spc, input logic stl,
                       input logic br, input logic [W_BRID-1:0] bid,
                       input logic [ADDR-1:0] tgt, input logic hlt);
    start_i = st; start_pc_i = spc; stall_i = stl;
    br_taken_i = br; br_id_i = bid; br_target_i = tgt; halt_i = hlt;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Push the observation expected during this cycle, then advance one cycle.
  task automatic obs(input int st, input int h, input int f, input int b,
                     input int brid, input int pc);
    exp_q.push_back(pack(st, h, f, b, brid, pc));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    @(posedge clk); #1;

    // Reset values while held in reset, then after release.
    obs(0, 0, 0, 1, 0, 16'h0000);
    obs(0, 0, 0, 1, 0, 16'h0000);
    reset = 1'b1;
    obs(0, 0, 0, 1, 0, 16'h0000);

    // IDLE ignores redirect and halt.
    drive(1'b0, '0, 1'b0, 1'b1, 4'd0, 16'h0A00, 1'b1);
    obs(0, 0, 0, 1, 0, 16'h0000);
    idle();
    obs(0, 0, 0, 1, 0, 16'h0000);

    // Start at 0x0100 and run sequentially.
    drive(1'b1, 16'h0100, 1'b0, 1'b0, '0, '0, 1'b0);
    obs(0, 0, 0, 1, 0, 16'h0000);
    idle();
    for (int i = 0; i < 5; i++) obs(1, 0, 0, 0, 0, 16'h0100 + i);

    // Stall for 3 cycles at 0x0105.
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    obs(1, 0, 0, 0, 0, 16'h0105);
    obs(1, 0, 0, 0, 0, 16'h0105);
    obs(1, 0, 0, 0, 0, 16'h0105);
    idle();
    obs(1, 0, 0, 0, 0, 16'h0105);
    obs(1, 0, 0, 0, 0, 16'h0106);

    // Redirect overriding stall.
    drive(1'b0, '0, 1'b1, 1'b1, 4'd0, 16'h0200, 1'b0);
    obs(1, 0, 0, 1, 0, 16'h0107);
    idle();
    obs(1, 0, 1, 0, 1, 16'h0200);
    // Stale epoch is ignored.
    drive(1'b0, '0, 1'b0, 1'b1, 4'd0, 16'h0300, 1'b0);
    obs(1, 0, 0, 0, 1, 16'h0201);
    idle();
    obs(1, 0, 0, 0, 1, 16'h0202);
    obs(1, 0, 0, 0, 1, 16'h0203);

    // Back-to-back redirects with incrementing epochs.
    drive(1'b0, '0, 1'b0, 1'b1, 4'd1, 16'h0400, 1'b0);
    obs(1, 0, 0, 1, 1, 16'h0204);
    drive(1'b0, '0, 1'b0, 1'b1, 4'd2, 16'h0500, 1'b0);
    obs(1, 0, 1, 1, 2, 16'h0400);
    idle();
    obs(1, 0, 1, 0, 3, 16'h0500);
    obs(1, 0, 0, 0, 3, 16'h0501);

    // 13 more redirects: epoch wraps 15 -> 0, then PC wraps 0xFFFF -> 0.
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 4'((3 + i) % 16), 16'hFFF0 + 16'(i), 1'b0);
      obs(1, 0, (i > 0) ? 1 : 0, 1, (3 + i) % 16, (i == 0) ? 16'h0502 : 16'hFFF0 + i - 1);
    end
    idle();
    obs(1, 0, 1, 0, 0, 16'hFFFC);
    obs(1, 0, 0, 0, 0, 16'hFFFD);
    obs(1, 0, 0, 0, 0, 16'hFFFE);
    obs(1, 0, 0, 0, 0, 16'hFFFF);
    obs(1, 0, 0, 0, 0, 16'h0000);
    obs(1, 0, 0, 0, 0, 16'h0001);

    // Halt, ignore halt/stall/stale redirect in HALT, then valid redirect.
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    obs(1, 0, 0, 0, 0, 16'h0002);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    obs(2, 1, 0, 1, 0, 16'h0002);
    drive(1'b0, '0, 1'b0, 1'b1, 4'd5, 16'h0900, 1'b0);
    obs(2, 1, 0, 1, 0, 16'h0002);
    drive(1'b0, '0, 1'b0, 1'b1, 4'd0, 16'h0300, 1'b0);
    obs(2, 1, 0, 1, 0, 16'h0002);
    idle();
    obs(1, 0, 1, 0, 1, 16'h0300);

    // Second halt, then restart at 0x0010.
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    obs(1, 0, 0, 0, 1, 16'h0301);
    drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 1'b0);
    obs(2, 1, 0, 1, 1, 16'h0301);
    idle();
    obs(1, 0, 0, 0, 1, 16'h0010);
    obs(1, 0, 0, 0, 1, 16'h0011);

    // Redirect and start together in HALT: redirect wins.
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    obs(1, 0, 0, 0, 1, 16'h0012);
    drive(1'b1, 16'h0777, 1'b0, 1'b1, 4'd1, 16'h0AAA, 1'b0);
    obs(2, 1, 0, 1, 1, 16'h0012);
    idle();
    obs(1, 0, 1, 0, 2, 16'h0AAA);

    // Halt and redirect together in RUN: redirect taken, no HALT.
    drive(1'b0, '0, 1'b0, 1'b1, 4'd2, 16'h0C00, 1'b1);
    obs(1, 0, 0, 1, 2, 16'h0AAB);
    // start_i in RUN is ignored.
    drive(1'b1, 16'h5555, 1'b0, 1'b0, '0, '0, 1'b0);
    obs(1, 0, 1, 0, 3, 16'h0C00);
    idle();
    obs(1, 0, 0, 0, 3, 16'h0C01);

    // Asynchronous reset mid-RUN: outputs return before any clock edge.
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (actual() === pack(0, 0, 0, 1, 0, 16'h0000)) n_pass++;
    else $display("FAIL async_reset got %h want %h", actual(), pack(0, 0, 0, 1, 0, 16'h0000));
    @(posedge clk); #1;
    obs(0, 0, 0, 1, 0, 16'h0000);
    reset = 1'b1;
    obs(0, 0, 0, 1, 0, 16'h0000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
